// File: rtl/calc_seq_core.sv
// calc_seq_core: sequential calculator core.
// Owns the operator-select FSM, operand latching, an 8-operation ALU and an
// iterative double-dabble binary-to-BCD converter (2W add-3/shift cycles).
// Optional build macro: CALC_AUTO_RECALC_EN -- when defined, a change of a or b
// while showing a result starts a new calculation without an enter pulse.
// state_dbg mirrors the FSM state register for observation.
module calc_seq_core #(
  parameter int W       = 4,
  parameter int DIGITS  = 4,
  parameter int NUM_OPS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  input  logic                  up,
  input  logic                  down,
  input  logic                  enter,
  input  logic                  back,
  output logic [2:0]            op,
  output logic [1:0]            disp_sel,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic [2*W-1:0]        result,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            state_dbg
);

  localparam int RW = 2 * W;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(RW);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Smallest magnitude that no longer fits in DIGITS decimal digits.
  localparam logic [63:0] BCD_LIMIT = pow10(DIGITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OP_SEL = 3'd1,
    S_CALC   = 3'd2,
    S_CONV   = 3'd3,
    S_RES    = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      op_nxt, op_inc, op_dec;
  logic [RW-1:0]   ax, bx, alu_val;
  logic            alu_neg, div_zero, over;
  logic [RW-1:0]   conv_val, bin_work;
  logic            conv_neg;
  logic [BW-1:0]   bcd_work, bcd_adj, bcd_shift;
  logic [CW-1:0]   cnt;
  logic            conv_last;
`ifdef CALC_AUTO_RECALC_EN
  logic [W-1:0]    a_lat, b_lat;
`endif

  assign ax        = {{W{1'b0}}, a};
  assign bx        = {{W{1'b0}}, b};
  assign op_inc    = (op == 3'(NUM_OPS - 1)) ? 3'd0 : op + 3'd1;
  assign op_dec    = (op == 3'd0) ? 3'(NUM_OPS - 1) : op - 3'd1;
  assign conv_last = (cnt == CW'(RW - 1));
  assign state_dbg = state;

  // ALU: evaluated from the live operands; only consumed in CALC.
  always_comb begin
    alu_val  = '0;
    alu_neg  = 1'b0;
    div_zero = 1'b0;
    case (op)
      3'd0: alu_val = ax + bx;
      3'd1: begin
        if (a < b) begin
          alu_val = bx - ax;
          alu_neg = 1'b1;
        end else begin
          alu_val = ax - bx;
        end
      end
      3'd2: alu_val = ax * bx;
      3'd3: if (b == '0) div_zero = 1'b1; else alu_val = ax / bx;
      3'd4: if (b == '0) div_zero = 1'b1; else alu_val = ax % bx;
      3'd5: alu_val = ax & bx;
      3'd6: alu_val = ax | bx;
      3'd7: alu_val = ax ^ bx;
      default: alu_val = '0;
    endcase
    over = ({{(64 - RW){1'b0}}, alu_val} >= BCD_LIMIT);
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    bcd_adj = bcd_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_adj[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_adj[4*d +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BW-2:0], bin_work[RW-1]};
  end

  // State and operation-code registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      op    <= 3'd0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
    end
  end

  // Next state; button priority is enter > back > up > down, one action per cycle.
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    case (state)
      S_IDLE: begin
        if (enter)          state_nxt = S_CALC;
        else if (back)      state_nxt = S_IDLE;
        else if (up | down) state_nxt = S_OP_SEL;
      end
      S_OP_SEL: begin
        if (enter)     state_nxt = S_CALC;
        else if (back) state_nxt = S_IDLE;
        else if (up)   op_nxt    = op_inc;
        else if (down) op_nxt    = op_dec;
      end
      S_CALC: begin
        if (div_zero || over) state_nxt = S_ERR;
        else                  state_nxt = S_CONV;
      end
      S_CONV: begin
        if (conv_last) state_nxt = S_RES;
      end
      S_RES: begin
        if (enter)          state_nxt = S_CALC;
        else if (back)      state_nxt = S_IDLE;
        else if (up | down) state_nxt = S_OP_SEL;
`ifdef CALC_AUTO_RECALC_EN
        else if ((a != a_lat) || (b != b_lat)) state_nxt = S_CALC;
`endif
      end
      S_ERR: begin
        if (enter | back)   state_nxt = S_IDLE;
        else if (up | down) state_nxt = S_OP_SEL;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded display/status outputs.
  always_comb begin
    disp_sel = 2'd0;
    busy     = 1'b0;
    err      = 1'b0;
    case (state)
      S_OP_SEL:       disp_sel = 2'd1;
      S_CALC, S_CONV: busy     = 1'b1;
      S_RES:          disp_sel = 2'd2;
      S_ERR: begin
        disp_sel = 2'd3;
        err      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: latch the ALU result in CALC, run the converter in CONV and
  // publish bcd/result/neg together on the final conversion edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conv_val <= '0;
      conv_neg <= 1'b0;
      bin_work <= '0;
      bcd_work <= '0;
      cnt      <= '0;
      bcd      <= '0;
      result   <= '0;
      neg      <= 1'b0;
      done     <= 1'b0;
`ifdef CALC_AUTO_RECALC_EN
      a_lat    <= '0;
      b_lat    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_CALC: begin
          conv_val <= alu_val;
          conv_neg <= alu_neg;
          bin_work <= alu_val;
          bcd_work <= '0;
          cnt      <= '0;
`ifdef CALC_AUTO_RECALC_EN
          a_lat    <= a;
          b_lat    <= b;
`endif
        end
        S_CONV: begin
          bcd_work <= bcd_shift;
          bin_work <= {bin_work[RW-2:0], 1'b0};
          cnt      <= cnt + CW'(1);
          if (conv_last) begin
            bcd    <= bcd_shift;
            result <= conv_val;
            neg    <= conv_neg;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_core.sv
// tb_calc_seq_core: directed bench for calc_seq_core (W=4, DIGITS=4, NUM_OPS=8).
// A behavioural model (decimal arithmetic, mode/op bookkeeping) predicts every
// output each cycle; literal expectations pin the model at key points.
module tb_calc_seq_core;

  localparam int W       = 4;
  localparam int DIGITS  = 4;
  localparam int NUM_OPS = 8;
  localparam int BW      = 4 * DIGITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]    a = '0, b = '0;
  logic            up = 1'b0, down = 1'b0, enter = 1'b0, back = 1'b0;
  logic [2:0]      op;
  logic [1:0]      disp_sel;
  logic [BW-1:0]   bcd;
  logic            neg, busy, done, err;
  logic [2*W-1:0]  result;
  logic [2:0]      state_dbg;

  calc_seq_core #(.W(W), .DIGITS(DIGITS), .NUM_OPS(NUM_OPS)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .up(up), .down(down), .enter(enter),
    .back(back), .op(op), .disp_sel(disp_sel), .bcd(bcd), .neg(neg),
    .result(result), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- model state ----------------
  int              n_checks = 0;
  int              n_errors = 0;
  bit              chk_on   = 1'b0;
  int              exp_mode = 0;   // 0 idle, 1 op select, 2 result, 3 error
  logic [2:0]      exp_op   = 3'd0;
  logic            exp_busy = 1'b0;
  logic            exp_done = 1'b0;
  logic [BW-1:0]   exp_bcd  = '0;
  logic [2*W-1:0]  exp_result = '0;
  logic            exp_neg  = 1'b0;
  logic [BW-1:0]   exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_calc(input int opc, input int av, input int bv,
                                     output longint res, output bit ng, output bit er);
    longint lim;
    res = 0; ng = 1'b0; er = 1'b0;
    case (opc)
      0: res = av + bv;
      1: if (av < bv) begin res = bv - av; ng = 1'b1; end else res = av - bv;
      2: res = av * bv;
      3: if (bv == 0) er = 1'b1; else res = av / bv;
      4: if (bv == 0) er = 1'b1; else res = av % bv;
      5: res = av & bv;
      6: res = av | bv;
      default: res = av ^ bv;
    endcase
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    if (!er && res >= lim) er = 1'b1;
  endfunction

  function automatic logic [BW-1:0] to_bcd(input longint v);
    logic [BW-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("op", op, exp_op);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("bcd", bcd, exp_bcd);
      chk("result", result, exp_result);
      chk("neg", neg, exp_neg);
      if (!exp_busy) begin
        chk("disp_sel", disp_sel, exp_mode);
        chk("err", err, exp_mode == 3);
      end
      if (done) begin
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("sb_bcd", bcd, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    exp_done = 1'b0;
  endtask

  // Non-enter button pulse(s); model applies back > up > down.
  task automatic press(input bit p_up, input bit p_down, input bit p_back);
    up = p_up; down = p_down; back = p_back;
    tick();
    up = 1'b0; down = 1'b0; back = 1'b0;
    if (exp_mode == 1) begin
      if (p_back)      exp_mode = 0;
      else if (p_up)   exp_op = (exp_op == 3'(NUM_OPS - 1)) ? 3'd0 : exp_op + 3'd1;
      else if (p_down) exp_op = (exp_op == 3'd0) ? 3'(NUM_OPS - 1) : exp_op - 3'd1;
    end else begin
      if (p_back)              exp_mode = 0;
      else if (p_up || p_down) exp_mode = 1;
    end
  endtask

  // Full calculation: optional enter (with an optional simultaneous up),
  // optional stray up pulse before conversion tick up_at.
  task automatic calc(input bit use_enter, input bit with_up, input int up_at);
    longint r;
    bit     ng, er;
    if (use_enter) begin enter = 1'b1; up = with_up; end
    tick();
    enter = 1'b0; up = 1'b0;
    model_calc(int'(exp_op), int'(a), int'(b), r, ng, er);
    exp_busy = 1'b1;
    if (!er) exp_q.push_back(to_bcd(r));
    tick();
    if (er) begin
      exp_busy = 1'b0;
      exp_mode = 3;
      return;
    end
    for (int i = 1; i <= 2 * W; i++) begin
      if (i == up_at) up = 1'b1;
      tick();
      up = 1'b0;
    end
    exp_busy   = 1'b0;
    exp_mode   = 2;
    exp_done   = 1'b1;
    exp_bcd    = to_bcd(r);
    exp_result = (2*W)'(r);
    exp_neg    = ng;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    longint r;
    bit     ng, er;
    chk_on = 1'b1;

    // Model pins against hand-computed values.
    chk("pin_bcd16", to_bcd(16), 16'h0016);
    chk("pin_bcd225", to_bcd(225), 16'h0225);
    model_calc(1, 3, 9, r, ng, er);
    chk("pin_sub_res", r, 6);
    chk("pin_sub_neg", ng, 1);
    model_calc(4, 5, 0, r, ng, er);
    chk("pin_mod0_err", er, 1);

    // Reset.
    repeat (3) tick();
    chk("rst_disp", disp_sel, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_op", op, 0);
    rst = 1'b1;
    tick();

    // 1: ADD 7+9.
    press(1, 0, 0);
    a = 4'd7; b = 4'd9;
    calc(1, 0, 0);
    chk("t1_bcd", bcd, 16'h0016);
    chk("t1_result", result, 16);
    chk("t1_neg", neg, 0);
    chk("t1_done", done, 1);

    // 6: operand change while showing a result.
    a = 4'd8;
`ifdef CALC_AUTO_RECALC_EN
    calc(0, 0, 0);
    chk("t6_auto_bcd", bcd, 16'h0017);
    chk("t6_auto_done", done, 1);
`else
    repeat (2 * W + 4) tick();
    chk("t6_hold_bcd", bcd, 16'h0016);
`endif

    // 2: SUB 3-9 -> negative 6, then back to idle.
    press(1, 0, 0);
    press(1, 0, 0);
    a = 4'd3; b = 4'd9;
    calc(1, 0, 0);
    chk("t2_neg", neg, 1);
    chk("t2_bcd", bcd, 16'h0006);
    press(0, 0, 1);
    chk("t2_disp", disp_sel, 0);

    // 3: DIV by zero -> error, bcd holds.
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    a = 4'd5; b = 4'd0;
    calc(1, 0, 0);
    chk("t3_err", err, 1);
    chk("t3_disp", disp_sel, 3);
    chk("t3_bcd", bcd, 16'h0006);
    press(0, 0, 1);
    chk("t3_err_clr", err, 0);

    // 4: down-wrap to XOR, then MUL with a stray up during conversion.
    press(0, 1, 0);
    repeat (3) press(0, 1, 0);
    press(0, 1, 0);
    chk("t4_op_wrap", op, 7);
    a = 4'd15; b = 4'd10;
    calc(1, 0, 0);
    chk("t4_xor_bcd", bcd, 16'h0005);
    press(1, 0, 0);
    press(1, 0, 0);
    chk("t4_op_upwrap", op, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    a = 4'd15; b = 4'd15;
    calc(1, 0, 3);
    chk("t4_mul_bcd", bcd, 16'h0225);
    chk("t4_mul_res", result, 225);
    chk("t4_op_held", op, 2);

    // Priority: up+down -> up; enter beats up; back beats up.
    press(1, 1, 0);
    press(1, 1, 0);
    chk("pri_updown", op, 3);
    a = 4'd15; b = 4'd4;
    calc(1, 1, 0);
    chk("pri_enter_op", op, 3);
    chk("div_bcd", bcd, 16'h0003);
    press(1, 0, 1);
    chk("pri_back", disp_sel, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    a = 4'd14;
    calc(1, 0, 0);
    chk("mod_bcd", bcd, 16'h0002);
    press(1, 0, 0);
    press(1, 0, 0);
    a = 4'd12; b = 4'd10;
    calc(1, 0, 0);
    chk("and_bcd", bcd, 16'h0008);
    press(1, 0, 0);
    press(1, 0, 0);
    calc(1, 0, 0);
    chk("or_bcd", bcd, 16'h0014);

    // 5: asynchronous reset in the 4th conversion cycle.
    a = 4'd9; b = 4'd9;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    exp_busy = 1'b1;
    repeat (4) tick();
    exp_mode = 0; exp_op = 3'd0; exp_busy = 1'b0; exp_done = 1'b0;
    exp_bcd = '0; exp_result = '0; exp_neg = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("t5_bcd", bcd, 0);
    chk("t5_result", result, 0);
    chk("t5_op", op, 0);
    chk("t5_busy", busy, 0);
    chk("t5_disp", disp_sel, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Recovery after reset: ADD 1+2 from idle.
    a = 4'd1; b = 4'd2;
    calc(1, 0, 0);
    chk("rec_bcd", bcd, 16'h0003);
    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
